// File: rtl/demux_1in_2out.sv
// demux_1in_2out
//   Buffered 1-to-2 demultiplexer. Each word on the single valid/ready input
//   is routed by in_sel (0 -> A, 1 -> B) into a small per-output FIFO. A
//   stalled sink only blocks words bound for itself.
//
// Parameters
//   LENGTH  data width in bits
//   DEPTH   entries per output FIFO (power of two, >= 2)
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   enable                     low blocks new input words; outputs keep draining
//   in_valid/in_ready          input handshake
//   in_sel, in_data            destination select and word
//   out_valid_a/out_ready_a,Q_A  output A handshake and head word (0 when idle)
//   out_valid_b/out_ready_b,Q_B  output B handshake and head word (0 when idle)
//   count_a, count_b           16-bit delivered-word counters (DEMUX_COUNT_EN)
//
// Build option
//   DEMUX_COUNT_EN  adds count_a/count_b, incremented on each read handshake.

// One output FIFO. Pointers carry an extra wrap bit so full and empty are
// distinguishable without a separate occupancy counter.
module demux_lane #(
  parameter int LENGTH = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [LENGTH-1:0] wr_data,
  input  logic              rd_ready,
  output logic              full,
  output logic              valid,
  output logic [LENGTH-1:0] q
);
  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]       wr_ptr, rd_ptr;
  logic [LENGTH-1:0] mem [DEPTH];
  logic              wr_fire, rd_fire;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid   = (wr_ptr != rd_ptr);
  // Guard on full locally as well, so an upstream slip cannot overwrite the head.
  assign wr_fire = wr_en & ~full;
  assign rd_fire = valid & rd_ready;
  assign q       = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

module demux_1in_2out #(
  parameter int LENGTH = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [LENGTH-1:0] in_data,
  output logic              out_valid_a,
  input  logic              out_ready_a,
  output logic [LENGTH-1:0] Q_A,
  output logic              out_valid_b,
  input  logic              out_ready_b,
  output logic [LENGTH-1:0] Q_B
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]       count_a,
  output logic [15:0]       count_b
`endif
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic              sel;
    logic [LENGTH-1:0] data;
  } req_t;

  req_t                               req;
  logic                               in_fire;
  logic [NUM_LANES-1:0]               wr_en, rd_ready, full, valid;
  logic [NUM_LANES-1:0][LENGTH-1:0]   q;

  assign req = '{sel: in_sel, data: in_data};

  // Only registered full flags feed in_ready; out_ready never reaches it, so a
  // read on a full FIFO frees the slot for the next cycle, not this one.
  assign in_ready = ~rst & enable & ~full[req.sel];
  assign in_fire  = in_valid & in_ready;
  assign rd_ready = {out_ready_b, out_ready_a};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wr_en[i] = in_fire & (req.sel == 1'(i));

    demux_lane #(
      .LENGTH (LENGTH),
      .DEPTH  (DEPTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[i]),
      .wr_data  (req.data),
      .rd_ready (rd_ready[i]),
      .full     (full[i]),
      .valid    (valid[i]),
      .q        (q[i])
    );
  end

  assign out_valid_a = valid[0];
  assign out_valid_b = valid[1];
  assign Q_A         = q[0];
  assign Q_B         = q[1];

`ifdef DEMUX_COUNT_EN
  logic [NUM_LANES-1:0] rd_fire;
  assign rd_fire = valid & rd_ready;

  // Free-running delivery counters, wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_a <= '0;
      count_b <= '0;
    end else begin
      if (rd_fire[0]) count_a <= count_a + 16'd1;
      if (rd_fire[1]) count_b <= count_b + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_demux_1in_2out.sv
module tb_demux_1in_2out;
  logic        clk = 0;
  logic        rst, enable, in_valid, in_sel, out_ready_a, out_ready_b;
  logic [31:0] in_data;
  logic        in_ready, out_valid_a, out_valid_b;
  logic [31:0] Q_A, Q_B;
`ifdef DEMUX_COUNT_EN
  logic [15:0] count_a, count_b;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  demux_1in_2out #(.LENGTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid_a(out_valid_a), .out_ready_a(out_ready_a), .Q_A(Q_A),
    .out_valid_b(out_valid_b), .out_ready_b(out_ready_b), .Q_B(Q_B)
`ifdef DEMUX_COUNT_EN
    , .count_a(count_a), .count_b(count_b)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on every output handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_a && out_ready_a) begin
        if (qa.size() == 0) chk("a_unexpected", Q_A, 32'hxxxxxxxx);
        else chk("q_a", Q_A, qa.pop_front());
      end else if (!out_valid_a) chk("q_a_idle", Q_A, 32'h0);
      if (out_valid_b && out_ready_b) begin
        if (qb.size() == 0) chk("b_unexpected", Q_B, 32'hxxxxxxxx);
        else chk("q_b", Q_B, qb.pop_front());
      end else if (!out_valid_b) chk("q_b_idle", Q_B, 32'h0);
    end
  end

  // Present one word, wait (bounded) for acceptance, push expectation at the
  // accepting edge. Returns at #1 after that edge with in_valid low.
  task automatic send(input logic s, input logic [31:0] d, output int waits);
    in_valid = 1; in_sel = s; in_data = d; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %h never accepted", d);
      @(posedge clk);
    end else begin
      @(posedge clk);
      if (s) qb.push_back(d); else qa.push_back(d);
    end
    #1 in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    rst = 1; enable = 1; in_valid = 0; in_sel = 0; in_data = 0;
    out_ready_a = 1; out_ready_b = 1;

    // Reset: in_ready held low even with enable high and input valid.
    in_valid = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_valid", {30'b0, out_valid_a, out_valid_b}, 32'd0);
    chk("rst_qa", Q_A, 32'h0);
    chk("rst_qb", Q_B, 32'h0);
    in_valid = 0;
    @(posedge clk); #1 rst = 0;

    // Routing and latency
    send(0, 32'h1, w);
    chk("lat_a_valid", {31'b0, out_valid_a}, 32'd1);
    chk("lat_a_q", Q_A, 32'h1);
    chk("lat_b_quiet", {31'b0, out_valid_b}, 32'd0);
    send(1, 32'h2, w);
    chk("lat_b_q", Q_B, 32'h2);
    idle(2);

    // Backpressure on A, B still flows, then A drains in order
    out_ready_a = 0;
    send(0, 32'h11, w);
    send(0, 32'h12, w);
    in_valid = 1; in_sel = 0; in_data = 32'h13;
    @(negedge clk);
    chk("full_a_blocks", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1 in_valid = 0;
    send(1, 32'h22, w);
    chk("b_while_a_full", w, 0);
    out_ready_a = 1;
    send(0, 32'h13, w);
    chk("a_accept_after_drain", w, 1);
    idle(4);

    // Steady-state stream: one word per cycle, pointers wrap repeatedly
    for (int i = 0; i < 16; i++) begin
      send(0, i, w);
      if (w != 0) chk("stream_throughput", w, 0);
    end
    idle(4);
    chk("stream_drained", qa.size(), 0);

    // enable gating: B holds 2, enable low blocks new words, B drains
    out_ready_b = 0;
    send(1, 32'hB1, w);
    send(1, 32'hB2, w);
    enable = 0; in_valid = 1; in_sel = 0; in_data = 32'hDEAD;
    @(negedge clk);
    chk("en_low_ready", {31'b0, in_ready}, 32'd0);
    out_ready_b = 1;
    repeat (3) @(negedge clk);
    chk("en_low_ready_late", {31'b0, in_ready}, 32'd0);
    chk("en_a_no_write", {31'b0, out_valid_a}, 32'd0);
    chk("en_b_drained", {31'b0, out_valid_b}, 32'd0);
    chk("en_b_sb", qb.size(), 0);
    @(posedge clk); #1 in_valid = 0; enable = 1;

    // Reset mid-operation discards stored words
    out_ready_a = 0; out_ready_b = 0;
    send(0, 32'hA1, w);
    send(1, 32'hC1, w);
    rst = 1; qa.delete(); qb.delete();
    @(posedge clk); #1 rst = 0;
    chk("midrst_valid", {30'b0, out_valid_a, out_valid_b}, 32'd0);
    out_ready_a = 1; out_ready_b = 1;
    idle(4);

`ifdef DEMUX_COUNT_EN
    chk("cnt_a_zero", {16'b0, count_a}, 32'd0);
    chk("cnt_b_zero", {16'b0, count_b}, 32'd0);
    for (int i = 0; i < 5; i++) send(0, 32'h100 + i, w);
    for (int i = 0; i < 3; i++) send(1, 32'h200 + i, w);
    idle(4);
    chk("cnt_a", {16'b0, count_a}, 32'd5);
    chk("cnt_b", {16'b0, count_b}, 32'd3);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("cnt_a_rst", {16'b0, count_a}, 32'd0);
    chk("cnt_b_rst", {16'b0, count_b}, 32'd0);
`endif

    idle(2);
    chk("end_sb_a", qa.size(), 0);
    chk("end_sb_b", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/demux_1in_2out.md
# demux_1in_2out

Buffered 1-to-2 demultiplexer: accepts LENGTH-bit words on a single valid/ready input port and routes each to output A or B according to a per-word select bit. Each output has its own small FIFO, so a stalled sink does not block traffic bound for the other sink. It sits on the fan-out side of the datapath, alongside the 2-to-1 selector, for example to split one word stream between the UART transmit path and the register file.

## Interface
- LENGTH, 32, data width in bits
- DEPTH, 2, entries per output FIFO; power of two, minimum 2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  acceptance enable; low blocks new input words, draining continues
- in_valid  input  1  input word present
- in_ready  output  1  input word will be accepted this cycle
- in_sel  input  1  destination of input word: 0 selects A, 1 selects B
- in_data  input  LENGTH  input word
- out_valid_a / out_valid_b  output  1  head entry of FIFO A / FIFO B valid
- out_ready_a / out_ready_b  input  1  sink A / sink B takes the head entry
- Q_A / Q_B  output  LENGTH  head entry of FIFO A / FIFO B; 0 when the matching out_valid is low
- count_a / count_b  output  16  words delivered on A / B; present only with DEMUX_COUNT_EN

## Operation
- Each FIFO has a write pointer and read pointer of log2(DEPTH)+1 bits. Full: pointer MSBs differ and low bits are equal. Empty: pointers are equal.
- in_ready = enable & ~full(in_sel). It is combinational from enable, in_sel and registered full flags only, with no path from out_ready_*.
- Write occurs when in_valid & in_ready: in_data is stored in the FIFO chosen by in_sel, and that write pointer increments.
- Read on X occurs when out_valid_X & out_ready_X, and that read pointer increments. X is A or B.
- out_valid_X = ~empty(X). Q_X = mem_X[rd_ptr_X] when valid, otherwise 0.
- Pointers wrap modulo 2*DEPTH. Order within each FIFO is strictly FIFO.
- A simultaneous write and read on the same FIFO are both performed and occupancy is unchanged.
- When a FIFO is full, a simultaneous read does not enable a same-cycle write, because in_ready was already low.
- Writes to one FIFO and reads from the other are fully independent.
- in_valid high with in_ready low causes no state change. The source must hold in_data and in_sel stable until acceptance.
- enable low keeps in_ready at 0; both outputs keep draining normally.
- Reset clears all pointers and counters. FIFO contents are discarded, including a reset asserted mid-stream.

## Timing
- Reset values:
  - in_ready = 0 while rst is high, then enable-dependent from the cycle after release.
  - out_valid_a = out_valid_b = 0, Q_A = Q_B = 0, count_a = count_b = 0.
- Latency: a word accepted at edge N appears on Q_X with out_valid_X = 1 after edge N. It can be consumed at edge N+1.
- Throughput: one word per cycle sustained per direction while the sink keeps out_ready high.
- Full flags update on the edge that writes the last free entry. in_ready for that destination drops in the following cycle.

## Configuration
- DEMUX_COUNT_EN defined:
  - Ports count_a and count_b exist.
  - Each increments by 1 on every read handshake of its FIFO and wraps from 16'hFFFF to 0.
  - Reset clears both to 0.
- DEMUX_COUNT_EN undefined: the counters and ports are absent and all other behaviour is identical.

## Test plan
- Reset and routing:
  - Stimulus: rst high 2 cycles, then enable=1, out_ready_a=out_ready_b=1; send 32'h00000001 with sel=0, then 32'h00000002 with sel=1.
  - Response: all outputs 0 during reset; Q_A=1 one cycle after the first accept; Q_B=2 one cycle after the second; no output on the wrong port.
- Backpressure and full:
  - Stimulus: out_ready_a=0; send 3 words with sel=0 (DEPTH=2).
  - Response: first two accepted; in_ready=0 on the third; B traffic still accepted.
  - Then raise out_ready_a: the third word is accepted after one drain; order on A is 1,2,3.
- Simultaneous read/write at steady state:
  - Stimulus: continuous sel=0 stream 0..15 with out_ready_a=1.
  - Response: one word accepted per cycle; A delivers 0..15 in order; pointers wrap with no loss.
- enable gating:
  - Stimulus: FIFO B holds 2 words; set enable=0.
  - Response: in_ready=0 and no new writes; B still drains both words.
- Reset mid-operation:
  - Stimulus: both FIFOs partially full; assert rst for 1 cycle.
  - Response: out_valid_a=out_valid_b=0 next cycle; previously stored words are never delivered.
- Counters (DEMUX_COUNT_EN):
  - Stimulus: deliver 5 words on A and 3 on B.
  - Response: count_a=5, count_b=3; reset returns both to 0.
